writeback: RTL and testbench
============================

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the clock; rst is the reset, sampled on the rising edge of clk.
REQ-002 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 IR  in  32  instruction from the memory stage.
REQ-005 R_in  in  32  execute result (ALU result or effective address).
REQ-006 M_in  in  32  word read from data memory, naturally aligned.
REQ-007 PC  in  32  instruction address.
REQ-008 v_in  in  1  upstream valid.
REQ-009 stall  in  1  global stall.
REQ-010 r_out  out  1  ready to upstream; combinational, equals ~stall & ~rst.
REQ-011 WB_address  out  5  destination register to the register file.
REQ-012 WB_data  out  32  write data to the register file.
REQ-013 v_wb  out  1  writeback valid.
REQ-014 trap  out  1  one-cycle pulse flagging a misaligned load.
REQ-015 retired  out  64  count of instructions accepted without a trap.

Function
REQ-016 The block SHALL accept an instruction when v_in & r_out is high at a clk edge; outputs SHALL reflect it one cycle later.
REQ-017 WB_data source SHALL be selected by IR[6:0]:
- JAL 1101111 and JALR 1100111 -> PC+4, mod 2^32.
- Loads 0000011 -> extracted load data (REQ-018).
- LUI, AUIPC, OP-IMM and OP -> R_in.
REQ-018 Load extraction SHALL use byte offset R_in[1:0] and IR[14:12]:
- LB 000 / LBU 100: selected byte, sign- or zero-extended.
- LH 001 / LHU 101: halfword at R_in[1]*16, sign- or zero-extended.
- LW 010: full M_in.
REQ-019 v_wb SHALL be 1 for exactly one cycle per accepted instruction that writes a register with IR[11:7] != 0 and no trap.
REQ-020 Branches 1100011, stores 0100011, unknown opcodes and rd=x0 SHALL give v_wb=0 and SHALL NOT trap.
REQ-021 Whenever v_wb=0, WB_address and WB_data SHALL be 0, because the register file writes on every edge and must only ever hit x0 while idle.
REQ-022 Misaligned load SHALL raise trap for one cycle with v_wb=0:
- LH/LHU with R_in[0]=1.
- LW with R_in[1:0] != 0.
REQ-023 retired SHALL increment by 1 on each accepted instruction that does not trap, including non-writing instructions, and SHALL wrap from 2^64-1 to 0.
REQ-024 While stall=1, no instruction SHALL be accepted; the next edge SHALL drive v_wb=0, trap=0 and zero WB outputs, and retired SHALL hold.
REQ-025 v_in=0 with stall=0 SHALL produce an idle cycle, with outputs as in REQ-024.
REQ-026 Back-to-back acceptance SHALL be supported at one instruction per cycle with no bubble.

Reset
REQ-027 On rst=1 at an edge, the block SHALL set v_wb=0, trap=0, WB_address=0, WB_data=0 and retired=0.
REQ-028 An instruction presented during a reset cycle SHALL be discarded: it is not written back and not counted.
REQ-029 r_out SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst deasserts, if stall=0.

Structure
REQ-030 Opcode constants (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP_IMM) and load funct3 codes SHALL live in a shared package used with the decode and read stages.
REQ-031 Load extraction SHALL be a sub-module load_align with inputs M_in, offset and funct3, and outputs data and misaligned; it is purely combinational.
REQ-032 All other state SHALL be held in this module's registers; no other sub-modules.

Verification
REQ-033 LB, M_in=0x80FF7F01, R_in[1:0]=3 -> WB_data=0xFFFFFF80, v_wb=1; LBU under the same conditions -> 0x00000080.
REQ-034 JAL with PC=0xFFFFFFFC and rd=x1 -> WB_data=0x00000000, WB_address=1, v_wb=1 next cycle.
REQ-035 LW with R_in=0x1002 -> trap=1, v_wb=0, WB_address=0, and retired unchanged.
REQ-036 Four back-to-back ADDI results with stall asserted on the third beat -> the third is held off, then written after stall drops; v_wb pulses 4 times; retired=4.
REQ-037 ADD to rd=x0, followed by SW -> v_wb=0 with zero outputs in both cycles; retired increments by 2.
REQ-038 rst asserted in the same cycle as a valid LW -> no writeback, retired=0, and r_out=1 the cycle after release.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared opcode / funct3 constants and the write-data source decode used by
// the decode, read and writeback stages.
package writeback_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Where the register-file write data comes from; SRC_NONE means the
    // instruction never writes a register.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_LINK   = 2'd1,
        SRC_LOAD   = 2'd2,
        SRC_RESULT = 2'd3
    } wb_src_e;

    function automatic wb_src_e wb_source(input logic [6:0] opcode);
        wb_src_e src;
        case (opcode)
            OPC_JAL, OPC_JALR:                     src = SRC_LINK;
            OPC_LOAD:                              src = SRC_LOAD;
            OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: src = SRC_RESULT;
            OPC_STORE, OPC_BRANCH:                 src = SRC_NONE;
            default:                               src = SRC_NONE;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/writeback_if.sv
// Memory-stage to writeback bus plus the register-file write port.
// master: the upstream stage / register file side; slave: the writeback stage.
interface writeback_if;
    logic [31:0] IR;
    logic [31:0] R_in;
    logic [31:0] M_in;
    logic [31:0] PC;
    logic        v_in;
    logic        stall;
    logic        r_out;
    logic [4:0]  WB_address;
    logic [31:0] WB_data;
    logic        v_wb;
    logic        trap;
    logic [63:0] retired;

    modport master (
        output IR, R_in, M_in, PC, v_in, stall,
        input  r_out, WB_address, WB_data, v_wb, trap, retired
    );

    modport slave (
        input  IR, R_in, M_in, PC, v_in, stall,
        output r_out, WB_address, WB_data, v_wb, trap, retired
    );
endinterface

// File: rtl/writeback_load_align.sv
// Combinational load extraction: picks the byte/halfword/word out of the
// aligned memory word and flags accesses that straddle their natural size.
module load_align
    import writeback_pkg::*;
(
    input  logic [31:0] M_in,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection by byte offset
    always_comb begin
        byte_sel = 8'd0;
        case (offset)
            2'd0: byte_sel = M_in[7:0];
            2'd1: byte_sel = M_in[15:8];
            2'd2: byte_sel = M_in[23:16];
            2'd3: byte_sel = M_in[31:24];
            default: byte_sel = 8'd0;
        endcase
        half_sel = offset[1] ? M_in[31:16] : M_in[15:0];
    end

    // Extension and alignment check; reserved funct3 codes return zero
    always_comb begin
        data       = 32'd0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'd0, byte_sel};
            F3_LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            F3_LHU: begin
                data       = {16'd0, half_sel};
                misaligned = offset[0];
            end
            F3_LW: begin
                data       = M_in;
                misaligned = (offset != 2'd0);
            end
            default: begin
                data       = 32'd0;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Writeback stage: accepts one instruction per cycle, selects the register
// write data, flags misaligned loads and counts retired instructions.
module writeback
    import writeback_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    writeback_if.slave bus
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    wb_src_e     src;
    logic        ready;
    logic        accept;
    logic [31:0] ld_data;
    logic        ld_misaligned;
    logic        load_trap;
    logic [31:0] data_next;
    logic        wr_next;
    logic        trap_next;
    logic        count_next;

    logic        v_wb_q;
    logic        trap_q;
    logic [4:0]  addr_q;
    logic [31:0] data_q;
    logic [63:0] retired_q;

    // Immediate and upper instruction bits are consumed by earlier stages.
    logic unused_ir_bits;
    assign unused_ir_bits = ^bus.IR[31:15];

    load_align u_load_align (
        .M_in       (bus.M_in),
        .offset     (bus.R_in[1:0]),
        .funct3     (funct3),
        .data       (ld_data),
        .misaligned (ld_misaligned)
    );

    // Ready is purely combinational so a stall or reset blocks the same edge
    assign ready     = ~bus.stall & ~rst;
    assign bus.r_out = ready;

    // Decode, data select and next-state qualifiers for the accepted beat
    always_comb begin
        opcode    = bus.IR[6:0];
        rd        = bus.IR[11:7];
        funct3    = bus.IR[14:12];
        src       = wb_source(opcode);
        accept    = bus.v_in & ready;
        load_trap = (src == SRC_LOAD) & ld_misaligned;

        data_next = 32'd0;
        case (src)
            SRC_LINK:   data_next = bus.PC + 32'd4;
            SRC_LOAD:   data_next = ld_data;
            SRC_RESULT: data_next = bus.R_in;
            default:    data_next = 32'd0;
        endcase

        // rd=x0 still retires but never drives the write port
        wr_next    = accept & (src != SRC_NONE) & (rd != 5'd0) & ~load_trap;
        trap_next  = accept & load_trap;
        count_next = accept & ~load_trap;
    end

    // Output registers; address/data are forced to zero whenever no write
    // happens because the register file writes on every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_wb_q    <= 1'b0;
            trap_q    <= 1'b0;
            addr_q    <= 5'd0;
            data_q    <= 32'd0;
            retired_q <= 64'd0;
        end else begin
            v_wb_q <= wr_next;
            trap_q <= trap_next;
            addr_q <= wr_next ? rd : 5'd0;
            data_q <= wr_next ? data_next : 32'd0;
            if (count_next) begin
                retired_q <= retired_q + 64'd1;
            end
        end
    end

    assign bus.v_wb       = v_wb_q;
    assign bus.trap       = trap_q;
    assign bus.WB_address = addr_q;
    assign bus.WB_data    = data_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_writeback.sv
// Directed scoreboard bench for the writeback stage. The driver pushes the
// hand-computed expected outputs of every cycle; the monitor pops one entry
// per clock and compares.
module tb_writeback;

    typedef struct {
        logic        v;
        logic        t;
        logic [4:0]  a;
        logic [31:0] d;
        logic [63:0] ret;
    } exp_t;

    logic clk;
    logic rst;
    writeback_if bus ();

    writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act !== req)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        else
            pass_cnt++;
    endtask

    function automatic logic [31:0] ins(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
        return {17'd0, f3, rd, op};
    endfunction

    // One cycle of stimulus, driven at the falling edge, with its expected
    // registered response queued for the monitor.
    task automatic step(input logic r, input logic s, input logic v,
                        input logic [31:0] ir, input logic [31:0] rin,
                        input logic [31:0] min, input logic [31:0] pc,
                        input logic ev, input logic et, input logic [4:0] ea,
                        input logic [31:0] ed, input logic [63:0] eret);
        exp_t e;
        @(negedge clk);
        rst       = r;
        bus.stall = s;
        bus.v_in  = v;
        bus.IR    = ir;
        bus.R_in  = rin;
        bus.M_in  = min;
        bus.PC    = pc;
        #1;
        chk("r_out", {63'd0, bus.r_out}, {63'd0, ~(r | s)});
        e.v = ev; e.t = et; e.a = ea; e.d = ed; e.ret = eret;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the registered outputs just after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("v_wb",       {63'd0, bus.v_wb},       {63'd0, e.v});
                chk("trap",       {63'd0, bus.trap},       {63'd0, e.t});
                chk("WB_address", {59'd0, bus.WB_address}, {59'd0, e.a});
                chk("WB_data",    {32'd0, bus.WB_data},    {32'd0, e.d});
                chk("retired",    bus.retired,             e.ret);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011,
                           JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111,
                           AUIPC = 7'b0010111, OPR = 7'b0110011, OPI = 7'b0010011;

    initial begin
        int n;
        rst = 1'b1; bus.stall = 1'b0; bus.v_in = 1'b0;
        bus.IR = 32'd0; bus.R_in = 32'd0; bus.M_in = 32'd0; bus.PC = 32'd0;

        // Valid aligned LW presented during reset is dropped
        step(1, 0, 1, ins(LOAD, 5'd7, 3'b010), 32'h1000, 32'h1234_5678, 32'h0, 0, 0, 0, 32'h0, 0);
        step(1, 0, 1, ins(LOAD, 5'd7, 3'b010), 32'h1000, 32'h1234_5678, 32'h0, 0, 0, 0, 32'h0, 0);
        // First cycle after release: ready, idle
        step(0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 32'h0, 0);

        // Byte loads with sign and zero extension
        step(0, 0, 1, ins(LOAD, 5'd5, 3'b000), 32'h3, 32'h80FF_7F01, 32'h0, 1, 0, 5, 32'hFFFF_FF80, 1);
        step(0, 0, 1, ins(LOAD, 5'd6, 3'b100), 32'h3, 32'h80FF_7F01, 32'h0, 1, 0, 6, 32'h0000_0080, 2);
        // JAL link wraps
        step(0, 0, 1, ins(JAL, 5'd1, 3'b000), 32'h0, 32'h0, 32'hFFFF_FFFC, 1, 0, 1, 32'h0000_0000, 3);
        // Misaligned LW traps and does not retire
        step(0, 0, 1, ins(LOAD, 5'd7, 3'b010), 32'h1002, 32'hDEAD_BEEF, 32'h0, 0, 1, 0, 32'h0, 3);
        // Halfword loads
        step(0, 0, 1, ins(LOAD, 5'd8, 3'b001), 32'h2, 32'h80FF_7F01, 32'h0, 1, 0, 8, 32'hFFFF_80FF, 4);
        step(0, 0, 1, ins(LOAD, 5'd9, 3'b101), 32'h0, 32'h80FF_7F01, 32'h0, 1, 0, 9, 32'h0000_7F01, 5);
        step(0, 0, 1, ins(LOAD, 5'd9, 3'b101), 32'h1, 32'h80FF_7F01, 32'h0, 0, 1, 0, 32'h0, 5);
        step(0, 0, 1, ins(LOAD, 5'd9, 3'b001), 32'h3, 32'h80FF_7F01, 32'h0, 0, 1, 0, 32'h0, 5);
        // Aligned LW and byte at offset 1
        step(0, 0, 1, ins(LOAD, 5'd10, 3'b010), 32'h1000, 32'hDEAD_BEEF, 32'h0, 1, 0, 10, 32'hDEAD_BEEF, 6);
        step(0, 0, 1, ins(LOAD, 5'd11, 3'b000), 32'h1, 32'h80FF_7F01, 32'h0, 1, 0, 11, 32'h0000_007F, 7);
        step(0, 0, 1, ins(LOAD, 5'd11, 3'b000), 32'h2, 32'h80FF_7F01, 32'h0, 1, 0, 11, 32'hFFFF_FFFF, 8);
        // JALR, LUI, AUIPC
        step(0, 0, 1, ins(JALR, 5'd2, 3'b000), 32'h55, 32'h0, 32'h0000_0100, 1, 0, 2, 32'h0000_0104, 9);
        step(0, 0, 1, ins(LUI, 5'd3, 3'b000), 32'h1234_5000, 32'h0, 32'h0, 1, 0, 3, 32'h1234_5000, 10);
        step(0, 0, 1, ins(AUIPC, 5'd31, 3'b000), 32'hA5A5_0000, 32'h0, 32'h40, 1, 0, 31, 32'hA5A5_0000, 11);
        // Non-writing instructions still retire
        step(0, 0, 1, ins(BRANCH, 5'd4, 3'b000), 32'h1, 32'h0, 32'h0, 0, 0, 0, 32'h0, 12);
        step(0, 0, 1, ins(OPR, 5'd0, 3'b000), 32'h77, 32'h0, 32'h0, 0, 0, 0, 32'h0, 13);
        step(0, 0, 1, ins(STORE, 5'd12, 3'b010), 32'h1001, 32'h0, 32'h0, 0, 0, 0, 32'h0, 14);
        step(0, 0, 1, ins(7'b1111111, 5'd13, 3'b000), 32'h9, 32'h0, 32'h0, 0, 0, 0, 32'h0, 15);
        // Stalled misaligned load: no trap, no count
        step(0, 1, 1, ins(LOAD, 5'd7, 3'b010), 32'h1003, 32'h0, 32'h0, 0, 0, 0, 32'h0, 15);
        // Idle cycle
        step(0, 0, 0, ins(OPI, 5'd7, 3'b000), 32'h5, 32'h0, 32'h0, 0, 0, 0, 32'h0, 15);

        // Reset mid-run, then four ADDIs with stall on the third beat
        step(1, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 32'h0, 0);
        step(0, 0, 1, ins(OPI, 5'd12, 3'b000), 32'd1, 32'h0, 32'h0, 1, 0, 12, 32'd1, 1);
        step(0, 0, 1, ins(OPI, 5'd13, 3'b000), 32'd2, 32'h0, 32'h0, 1, 0, 13, 32'd2, 2);
        step(0, 1, 1, ins(OPI, 5'd14, 3'b000), 32'd3, 32'h0, 32'h0, 0, 0, 0, 32'h0, 2);
        step(0, 0, 1, ins(OPI, 5'd14, 3'b000), 32'd3, 32'h0, 32'h0, 1, 0, 14, 32'd3, 3);
        step(0, 0, 1, ins(OPI, 5'd15, 3'b000), 32'd4, 32'h0, 32'h0, 1, 0, 15, 32'd4, 4);
        step(0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 32'h0, 4);

        // Drain the scoreboard within a bounded number of cycles
        @(negedge clk);
        bus.v_in = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        else
            pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
